// File: rtl/interrupt_sequencer.sv
// rtl/interrupt_sequencer.sv - 6502-style interrupt/BRK/RTI entry-exit sequencer
// Drives stack pushes, vector fetch and RTI pops on a shared byte-wide memory port.
module interrupt_sequencer #(
  parameter int                      NUM_SRC     = 3,
  parameter logic [16*NUM_SRC-1:0]   VEC_TABLE   = {16'hFFFE, 16'hFFFA, 16'hFFFC},
  parameter logic [NUM_SRC-1:0]      NMASK       = 3'b011,
  parameter logic [NUM_SRC-1:0]      EDGE_MASK   = 3'b010,
  parameter logic [NUM_SRC-1:0]      NOPUSH_MASK = 3'b001,
  parameter logic [7:0]              STACK_PAGE  = 8'h01
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic               brk_req,
  input  logic               is_rti,
  input  logic               start,
  output logic               done,
  output logic               busy,
  output logic [15:0]        mem_addr,
  output logic [7:0]         mem_wdata,
  output logic               mem_we,
  input  logic [7:0]         mem_rdata,
  input  logic [15:0]        pc_in,
  input  logic [7:0]         status_in,
  input  logic [7:0]         sp_in,
  output logic [15:0]        pc_out,
  output logic [7:0]         status_out,
  output logic [7:0]         sp_out,
  output logic [NUM_SRC-1:0] ack
);

  localparam int IW = (NUM_SRC > 2) ? $clog2(NUM_SRC) : 1;

  typedef enum logic [3:0] {
    IDLE, PUSH_PCH, PUSH_PCL, PUSH_P, VEC_LO, VEC_HI, VEC_CAP,
    POP_P, POP_PCL, POP_PCH, POP_CAP, DONE
  } state_t;

  state_t             state_q, state_d;
  logic [NUM_SRC-1:0] pend_q, pend_d;
  logic [NUM_SRC-1:0] prev_q;
  logic [IW-1:0]      sel_q, sel_d;
  logic               brk_q, brk_d;
  logic [7:0]         lo_q, lo_d;
  logic [15:0]        pc_q, pc_d;
  logic [7:0]         status_q, status_d;
  logic [7:0]         sp_q, sp_d;
  logic [NUM_SRC-1:0] ack_q, ack_d;

  logic [NUM_SRC-1:0] req, elig, edge_set, edge_clr;
  logic [IW-1:0]      pick;
  logic               found;
  logic [15:0]        vec;
  logic [7:0]         sp_m1, sp_m2, sp_p1, sp_p2, sp_p3;

  assign sp_m1 = sp_in - 8'd1;
  assign sp_m2 = sp_in - 8'd2;
  assign sp_p1 = sp_in + 8'd1;
  assign sp_p2 = sp_in + 8'd2;
  assign sp_p3 = sp_in + 8'd3;
  assign vec   = VEC_TABLE[{sel_q, 4'b0000} +: 16];

  // Edge sources are read from the pending latch, level sources straight from the pin.
  assign req      = (EDGE_MASK & pend_q) | (~EDGE_MASK & irq_src);
  assign elig     = req & (NMASK | {NUM_SRC{~status_in[2]}});
  assign edge_set = irq_src & ~prev_q & EDGE_MASK;
  assign edge_clr = (state_q == VEC_LO) ? ((NUM_SRC'(1) << sel_q) & EDGE_MASK) : '0;
  assign pend_d   = (pend_q & ~edge_clr) | edge_set;

  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (elig[i]) begin
        found = 1'b1;
        pick  = IW'(i);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    brk_d     = brk_q;
    lo_d      = lo_q;
    pc_d      = pc_q;
    status_d  = status_q;
    sp_d      = sp_q;
    ack_d     = ack_q;
    mem_addr  = 16'h0000;
    mem_wdata = 8'h00;
    mem_we    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (is_rti) begin
            state_d = POP_P;
            sp_d    = sp_p3;
            ack_d   = '0;
          end else if (found || brk_req) begin
            sel_d    = found ? pick : IW'(NUM_SRC - 1);
            brk_d    = ~found;
            state_d  = (found && NOPUSH_MASK[pick]) ? VEC_LO : PUSH_PCH;
            sp_d     = sp_in - 8'd3;
            status_d = status_in | 8'h04;
            ack_d    = found ? (NUM_SRC'(1) << pick) : (NUM_SRC'(1) << (NUM_SRC - 1));
          end else begin
            state_d  = DONE;
            pc_d     = pc_in;
            status_d = status_in;
            sp_d     = sp_in;
            ack_d    = '0;
          end
        end
      end
      PUSH_PCH: begin
        mem_addr  = {STACK_PAGE, sp_in};
        mem_wdata = pc_in[15:8];
        mem_we    = 1'b1;
        state_d   = PUSH_PCL;
      end
      PUSH_PCL: begin
        mem_addr  = {STACK_PAGE, sp_m1};
        mem_wdata = pc_in[7:0];
        mem_we    = 1'b1;
        state_d   = PUSH_P;
      end
      PUSH_P: begin
        mem_addr  = {STACK_PAGE, sp_m2};
        mem_wdata = {status_in[7:6], 1'b1, brk_q, status_in[3:0]};
        mem_we    = 1'b1;
        state_d   = VEC_LO;
      end
      VEC_LO: begin
        mem_addr = vec;
        state_d  = VEC_HI;
      end
      VEC_HI: begin
        mem_addr = vec + 16'd1;
        lo_d     = mem_rdata;
        state_d  = VEC_CAP;
      end
      VEC_CAP: begin
        pc_d    = {mem_rdata, lo_q};
        state_d = DONE;
      end
      POP_P: begin
        mem_addr = {STACK_PAGE, sp_p1};
        state_d  = POP_PCL;
      end
      POP_PCL: begin
        mem_addr = {STACK_PAGE, sp_p2};
        status_d = {mem_rdata[7:6], 1'b1, 1'b0, mem_rdata[3:0]};
        state_d  = POP_PCH;
      end
      POP_PCH: begin
        mem_addr = {STACK_PAGE, sp_p3};
        lo_d     = mem_rdata;
        state_d  = POP_CAP;
      end
      POP_CAP: begin
        pc_d    = {mem_rdata, lo_q};
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      pend_q   <= '0;
      prev_q   <= '0;
      sel_q    <= '0;
      brk_q    <= 1'b0;
      lo_q     <= 8'h00;
      pc_q     <= 16'h0000;
      status_q <= 8'h00;
      sp_q     <= 8'h00;
      ack_q    <= '0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      prev_q   <= irq_src;
      sel_q    <= sel_d;
      brk_q    <= brk_d;
      lo_q     <= lo_d;
      pc_q     <= pc_d;
      status_q <= status_d;
      sp_q     <= sp_d;
      ack_q    <= ack_d;
    end
  end

  assign done       = (state_q == DONE);
  assign busy       = (state_q != IDLE);
  assign pc_out     = pc_q;
  assign status_out = status_q;
  assign sp_out     = sp_q;
  assign ack        = ack_q;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// tb/tb_interrupt_sequencer.sv - directed-vector bench for interrupt_sequencer
module tb_interrupt_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  irq_src;
  logic        brk_req, is_rti, start;
  logic        done, busy, mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic [15:0] pc_in, pc_out;
  logic [7:0]  status_in, sp_in, status_out, sp_out;
  logic [2:0]  ack;

  logic        tb_we;
  logic [15:0] tb_addr;
  logic [7:0]  tb_data;
  logic [7:0]  mem [0:65535];
  logic [23:0] wr_log [0:63];
  int          wr_cnt = 0;
  int          base;
  int          n_cmp = 0;
  int          n_err = 0;
  int          lat;

  interrupt_sequencer dut (
    .clk(clk), .rst(rst), .irq_src(irq_src), .brk_req(brk_req), .is_rti(is_rti),
    .start(start), .done(done), .busy(busy), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_rdata(mem_rdata), .pc_in(pc_in), .status_in(status_in),
    .sp_in(sp_in), .pc_out(pc_out), .status_out(status_out), .sp_out(sp_out), .ack(ack)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    mem_rdata <= mem[mem_addr];
    if (mem_we) begin
      mem[mem_addr]       <= mem_wdata;
      wr_log[wr_cnt % 64] <= {mem_addr, mem_wdata};
      wr_cnt              <= wr_cnt + 1;
    end else if (tb_we) begin
      mem[tb_addr] <= tb_data;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [15:0] a, input logic [7:0] d);
    tb_we = 1'b1; tb_addr = a; tb_data = d;
    @(negedge clk);
    tb_we = 1'b0;
  endtask

  task automatic run(input logic [15:0] pc, input logic [7:0] st, input logic [7:0] sp,
                     input logic rti, input logic brk, output int l);
    base = wr_cnt;
    pc_in = pc; status_in = st; sp_in = sp; is_rti = rti; brk_req = brk; start = 1'b1;
    @(negedge clk);
    start = 1'b0; is_rti = 1'b0; brk_req = 1'b0;
    l = 1;
    while (!done && l < 20) begin
      @(negedge clk);
      l++;
    end
    check("done_seen", {31'd0, done}, 32'd1);
  endtask

  task automatic chk_wr(input int k, input logic [15:0] a, input logic [7:0] d);
    check($sformatf("wr%0d_addr", k), {16'd0, wr_log[(base + k) % 64][23:8]}, {16'd0, a});
    check($sformatf("wr%0d_data", k), {24'd0, wr_log[(base + k) % 64][7:0]}, {24'd0, d});
  endtask

  task automatic chk_out(input string tag, input int l, input int exp_l, input logic [15:0] pc,
                         input logic [7:0] st, input logic [7:0] sp, input logic [2:0] a,
                         input int nw);
    check({tag, "_lat"}, l, exp_l);
    check({tag, "_pc"}, {16'd0, pc_out}, {16'd0, pc});
    check({tag, "_status"}, {24'd0, status_out}, {24'd0, st});
    check({tag, "_sp"}, {24'd0, sp_out}, {24'd0, sp});
    check({tag, "_ack"}, {29'd0, ack}, {29'd0, a});
    check({tag, "_nwr"}, wr_cnt - base, nw);
  endtask

  task automatic pulse_nmi();
    irq_src[1] = 1'b1;
    @(negedge clk);
    irq_src[1] = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; irq_src = 3'b000; brk_req = 1'b0; is_rti = 1'b0; start = 1'b0;
    pc_in = 16'h0; status_in = 8'h0; sp_in = 8'h0;
    tb_we = 1'b0; tb_addr = 16'h0; tb_data = 8'h0;
    #2;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_we", {31'd0, mem_we}, 32'd0);
    check("rst_addr", {16'd0, mem_addr}, 32'd0);
    check("rst_pc", {16'd0, pc_out}, 32'd0);
    check("rst_ack", {29'd0, ack}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    poke(16'hFFFA, 8'h00); poke(16'hFFFB, 8'h90);
    poke(16'hFFFC, 8'h00); poke(16'hFFFD, 8'hF0);
    poke(16'hFFFE, 8'h00); poke(16'hFFFF, 8'hC0);

    // NMI entry
    pulse_nmi();
    run(16'h8123, 8'h24, 8'hFD, 1'b0, 1'b0, lat);
    chk_out("nmi", lat, 7, 16'h9000, 8'h24, 8'hFA, 3'b010, 3);
    chk_wr(0, 16'h01FD, 8'h81);
    chk_wr(1, 16'h01FC, 8'h23);
    chk_wr(2, 16'h01FB, 8'h24);
    @(negedge clk);

    // IRQ masked by I flag: pass-through
    irq_src[2] = 1'b1;
    run(16'h4321, 8'h24, 8'hF0, 1'b0, 1'b0, lat);
    chk_out("masked", lat, 1, 16'h4321, 8'h24, 8'hF0, 3'b000, 0);
    @(negedge clk);

    // IRQ serviced with I clear
    run(16'h4000, 8'h20, 8'hF0, 1'b0, 1'b0, lat);
    chk_out("irq", lat, 7, 16'hC000, 8'h24, 8'hED, 3'b100, 3);
    chk_wr(0, 16'h01F0, 8'h40);
    chk_wr(1, 16'h01EF, 8'h00);
    chk_wr(2, 16'h01EE, 8'h20);
    irq_src[2] = 1'b0;
    @(negedge clk);

    // RTI
    poke(16'h01FB, 8'hA1); poke(16'h01FC, 8'h34); poke(16'h01FD, 8'h12);
    run(16'h0000, 8'h00, 8'hFA, 1'b1, 1'b0, lat);
    chk_out("rti", lat, 5, 16'h1234, 8'hA1, 8'hFD, 3'b000, 0);
    @(negedge clk);

    // RTI wrapping the stack page, popped B flag cleared
    poke(16'h01FF, 8'h10); poke(16'h0100, 8'hCD); poke(16'h0101, 8'hAB);
    run(16'h0000, 8'h00, 8'hFE, 1'b1, 1'b0, lat);
    chk_out("rti_wrap", lat, 5, 16'hABCD, 8'h20, 8'h01, 3'b000, 0);
    @(negedge clk);

    // Reset source beats pending NMI; NMI serviced afterwards
    irq_src[0] = 1'b1;
    pulse_nmi();
    run(16'h1111, 8'h24, 8'hFD, 1'b0, 1'b0, lat);
    chk_out("reset_src", lat, 4, 16'hF000, 8'h24, 8'hFA, 3'b001, 0);
    irq_src[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    run(16'h2222, 8'h24, 8'hFD, 1'b0, 1'b0, lat);
    chk_out("nmi_after", lat, 7, 16'h9000, 8'h24, 8'hFA, 3'b010, 3);
    @(negedge clk);

    // BRK ignores the I flag and pushes B set
    run(16'h2000, 8'h24, 8'hFD, 1'b0, 1'b1, lat);
    chk_out("brk", lat, 7, 16'hC000, 8'h24, 8'hFA, 3'b100, 3);
    chk_wr(2, 16'h01FB, 8'h34);
    @(negedge clk);

    // Push wrapping below the stack page
    run(16'h5678, 8'h20, 8'h01, 1'b0, 1'b1, lat);
    chk_out("push_wrap", lat, 7, 16'hC000, 8'h24, 8'hFE, 3'b100, 3);
    chk_wr(0, 16'h0101, 8'h56);
    chk_wr(1, 16'h0100, 8'h78);
    chk_wr(2, 16'h01FF, 8'h30);
    @(negedge clk);

    // Asynchronous abort during PUSH_PCL
    base = wr_cnt;
    pc_in = 16'h5678; status_in = 8'h20; sp_in = 8'h01; brk_req = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0; brk_req = 1'b0;
    check("abort_pch_we", {31'd0, mem_we}, 32'd1);
    check("abort_pch_addr", {16'd0, mem_addr}, 32'h0101);
    @(negedge clk);
    check("abort_pcl_addr", {16'd0, mem_addr}, 32'h0100);
    rst = 1'b1;
    #1;
    check("abort_we", {31'd0, mem_we}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_addr", {16'd0, mem_addr}, 32'd0);
    check("abort_wdata", {24'd0, mem_wdata}, 32'd0);
    check("abort_pc", {16'd0, pc_out}, 32'd0);
    check("abort_sp", {24'd0, sp_out}, 32'd0);
    check("abort_status", {24'd0, status_out}, 32'd0);
    check("abort_ack", {29'd0, ack}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    check("abort_nwr", wr_cnt - base, 1);
    rst = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/interrupt_sequencer.md
INTERRUPT_SEQUENCER -- requirements
Module: interrupt_sequencer

Interface
REQ-001 Parameter NUM_SRC, 3: number of interrupt sources, 2..8; index 0 is highest priority.
REQ-002 Parameter VEC_TABLE, {16'hFFFE,16'hFFFA,16'hFFFC}: NUM_SRC x 16-bit vector-low addresses, entry i in bits [16i+15:16i] (default: 0 = reset, 1 = NMI, 2 = IRQ/BRK).
REQ-003 Parameter NMASK, 3'b011: bit i = 1 means source i ignores the I flag (status bit 2).
REQ-004 Parameter EDGE_MASK, 3'b010: bit i = 1 means rising-edge latched; otherwise level-sensitive.
REQ-005 Parameter NOPUSH_MASK, 3'b001: bit i = 1 means source i performs no stack writes.
REQ-006 Parameter STACK_PAGE, 8'h01: high address byte for stack accesses.
REQ-007 clk  in  1  the single clock; all logic on the rising edge.
REQ-008 rst  in  1  reset, asynchronous and active-high.
REQ-009 irq_src  in  NUM_SRC  raw interrupt requests.
REQ-010 brk_req, is_rti  in  1 each  qualifiers sampled with start.
REQ-011 start  in  1  one-cycle request from the instruction engine; honoured only in IDLE.
REQ-012 done  out  1  one-cycle pulse; all *_out and ack are valid in that cycle.
REQ-013 busy  out  1  high in every state except IDLE; the bus mux select.
REQ-014 mem_addr  out  16; mem_wdata  out  8; mem_we  out  1; mem_rdata  in  8: memory port, read data valid one cycle after the address.
REQ-015 pc_in  in  16; status_in  in  8; sp_in  in  8: engine state, held stable while busy.
REQ-016 pc_out  out  16; status_out  out  8; sp_out  out  8; ack  out  NUM_SRC (one-hot serviced source).

Function
REQ-017 States: IDLE, PUSH_PCH, PUSH_PCL, PUSH_P, VEC_LO, VEC_HI, VEC_CAP, POP_P, POP_PCL, POP_PCH, POP_CAP, DONE; unused encodings go to IDLE.
REQ-018 Edge-source pending bit: set on a 0->1 transition of irq_src[i] (registered previous value); cleared in the VEC_LO cycle of source i; set wins on a same-cycle set and clear.
REQ-019 Level-source request equals irq_src[i] sampled in IDLE; it is not latched.
REQ-020 Eligible source: request or pending set, and (NMASK[i] or status_in[2] == 0); the lowest eligible index is selected.
REQ-021 On start in IDLE, path priority is: is_rti -> POP_P; else eligible source -> PUSH_PCH, or VEC_LO if NOPUSH_MASK[i]; else brk_req -> BRK using entry NUM_SRC-1 (I flag ignored) -> PUSH_PCH; else -> DONE with pc_out = pc_in, status_out = status_in, sp_out = sp_in, ack = 0.
REQ-022 Push writes (mem_we = 1, each one cycle): PUSH_PCH {STACK_PAGE, sp_in} <- pc_in[15:8]; PUSH_PCL {STACK_PAGE, sp_in-1} <- pc_in[7:0]; PUSH_P {STACK_PAGE, sp_in-2} <- status_in with bit5 = 1 and bit4 = brk path.
REQ-023 VEC_LO drives the vector address; VEC_HI drives vector+1 and captures the low byte; VEC_CAP captures the high byte into pc_out; then DONE.
REQ-024 Interrupt exit values: sp_out = sp_in-3, also on no-push sources; status_out = status_in with bit2 = 1; ack = one-hot(i), or one-hot(NUM_SRC-1) for BRK.
REQ-025 RTI reads: POP_P at sp_in+1, POP_PCL at sp_in+2, POP_PCH at sp_in+3, capturing one cycle later. status_out = popped value with bit4 = 0 and bit5 = 1; sp_out = sp_in+3; ack = 0.
REQ-026 All stack offsets wrap modulo 256 within STACK_PAGE; the vector+1 address wraps modulo 65536.
REQ-027 Latency from the start cycle to done: push path 7 cycles, no-push path 4, RTI 5, pass-through 1.
REQ-028 mem_we is 0 outside the PUSH_* states; done is high only in DONE; DONE always returns to IDLE.
REQ-029 A start seen while not in IDLE is ignored.

Reset
REQ-030 While rst = 1: state = IDLE, all pending bits and edge registers 0, and every output 0 (mem_we, done, busy, ack, mem_addr, mem_wdata, pc_out, status_out, sp_out).
REQ-031 Asserting rst mid-sequence aborts it within the same cycle (asynchronous), with no further write issued.

Verification
REQ-032 NMI: pulse irq_src[1]; start with pc_in = 16'h8123, sp_in = 8'hFD, status_in = 8'h24 -> writes 01FD = 81, 01FC = 23, 01FB = 24; reads FFFA/FFFB = 00/90; done at start+7; pc_out = 9000, sp_out = FA, ack = 3'b010.
REQ-033 IRQ held high with status_in[2] = 1, start -> pass-through done at start+1, no writes, ack = 0.
REQ-034 RTI with sp_in = 8'hFA and stack 01FB = A1, 01FC = 34, 01FD = 12 -> pc_out = 1234, status_out = 8'hA1 with bit4 = 0 and bit5 = 1 (8'hA1), sp_out = FD, done at start+5.
REQ-035 Reset (irq_src[0]) and NMI both pending -> source 0 serviced with no writes, vector FFFC, sp_out = sp_in-3, done at start+4; NMI stays pending and is serviced on the next start.
REQ-036 sp_in = 8'h01 push sequence -> write addresses 0101, 0100, 01FF; assert rst during PUSH_PCL -> mem_we = 0 immediately and all outputs 0.
